// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: default byte width and the
// feeder state encodings. States are gray-coded so every legal transition
// flips exactly one bit.
package uart_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    GUARD = 2'b11,
    WAIT  = 2'b10
  } feeder_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO that buffers producer bytes ahead of the transmitter.
// It tracks an explicit fill count, so full and empty are plain decodes of
// that count. A write to a full FIFO is dropped and latches a sticky
// overflow flag. The current head entry is always presented on rd_data, so
// the consumer can capture it in the same cycle that it pops.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int DEPTH      = 8,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  input  logic                  ovf_clr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_W:0]       fill_count,
  output logic                  overflow
);

  localparam logic [ADDR_W:0] DEPTH_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic                  wr_accept;
  logic                  rd_accept;

  assign full      = (fill_count == DEPTH_COUNT);
  assign empty     = (fill_count == '0);
  assign wr_accept = wr_en && !full;
  assign rd_accept = pop && !empty;
  assign rd_data   = mem[rd_ptr];

  // Storage array; its contents are intentionally left untouched by reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; a simultaneous write and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_count <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({wr_accept, rd_accept})
        2'b10:   fill_count <= fill_count + (ADDR_W + 1)'(1);
        2'b01:   fill_count <= fill_count - (ADDR_W + 1)'(1);
        default: fill_count <= fill_count;
      endcase
    end
  end

  // Sticky overflow. A new drop wins over a clear that arrives in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Issue controller in front of the UART transmitter. It pulls one byte at a
// time from the local FIFO and presents it with a single-cycle tx_valid
// pulse. It then waits out one guard cycle so the transmitter can assert
// busy, and waits again until busy falls before it issues the next byte.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int DEPTH      = 8,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_W:0]       fill_count,
  output logic                  overflow,
  input  logic                  ovf_clr,
  input  logic                  busy,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid
);

  feeder_state_t         state;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head_data;

  assign pop = (state == IDLE) && !empty && !busy;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .pop        (pop),
    .ovf_clr    (ovf_clr),
    .rd_data    (head_data),
    .full       (full),
    .empty      (empty),
    .fill_count (fill_count),
    .overflow   (overflow)
  );

  // Issue sequencing: capture the head byte, pulse valid, guard, then wait for busy to fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data  <= head_data;
            tx_valid <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          tx_valid <= 1'b0;
          state    <= GUARD;
        end
        GUARD: begin
          state <= WAIT;
        end
        WAIT: begin
          if (!busy) begin
            state <= IDLE;
          end
        end
        default: begin
          tx_valid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder. A queue-based reference model predicts tx_valid,
// tx_data, the fill count, full, empty and overflow from the behavioural
// rules. Those predictions are compared on every cycle. Directed scenarios
// add literal expectations for latency, issue spacing, ordering and flag
// behaviour.
module tb_uart_tx_feeder;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          ovf_clr = 1'b0;
  logic          busy;
  logic          full;
  logic          empty;
  logic [AW:0]   fill_count;
  logic          overflow;
  logic [DW-1:0] tx_data;
  logic          tx_valid;

  logic man_busy  = 1'b0;
  logic auto_busy = 1'b0;
  logic tx_busy   = 1'b0;
  logic tx_pend   = 1'b0;
  int   tx_rem    = 0;

  int checks = 0;
  int errors = 0;
  int tb_cyc = 0;

  logic [DW-1:0] p_data[$];
  int            p_cyc[$];

  logic [DW-1:0] mq[$];
  logic          m_released = 1'b1;
  int            m_last = -100;
  int            m_cyc = 0;
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic          m_ovf = 1'b0;
  logic          m_acc;
  logic          m_issue;

  assign busy = auto_busy ? tx_busy : man_busy;

  uart_tx_feeder #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .empty      (empty),
    .fill_count (fill_count),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .busy       (busy),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter used to timestamp observed pulses
  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  // Reference model. The queue holds the bytes awaiting issue. A new issue
  // needs busy to have been seen low at least two cycles after the previous
  // pulse, and it must also see busy low and data queued in the deciding cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_released = 1'b1;
      m_last     = -100;
      m_valid    = 1'b0;
      m_data     = '0;
      m_ovf      = 1'b0;
    end else begin
      m_acc   = wr_en && (mq.size() < DEPTH);
      m_issue = m_released && !busy && (mq.size() > 0);
      m_valid = m_issue;
      if (m_issue) begin
        m_data     = mq.pop_front();
        m_released = 1'b0;
        m_last     = m_cyc + 1;
      end else if (!m_released && (m_cyc >= m_last + 2) && !busy) begin
        m_released = 1'b1;
      end
      if (m_acc) mq.push_back(wr_data);
      if (wr_en && !m_acc) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
    m_cyc = m_cyc + 1;
  end

  // Transmitter stand-in: busy rises the cycle after a pulse and stays high for 11 cycles
  always @(negedge clk) begin
    if (!rst) begin
      tx_busy = 1'b0;
      tx_pend = 1'b0;
      tx_rem  = 0;
    end else if (tx_pend) begin
      tx_pend = 1'b0;
      tx_busy = 1'b1;
      tx_rem  = 11;
    end else if (tx_busy) begin
      tx_rem = tx_rem - 1;
      if (tx_rem == 0) tx_busy = 1'b0;
    end
    if (rst && tx_valid) tx_pend = 1'b1;
  end

  // Pulse recorder
  always @(negedge clk) begin
    if (rst && tx_valid) begin
      p_data.push_back(tx_data);
      p_cyc.push_back(tb_cyc);
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s actual=%0h expected=%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    check_output("cmp_tx_valid", 32'(tx_valid), 32'(m_valid));
    check_output("cmp_tx_data", 32'(tx_data), 32'(m_data));
    check_output("cmp_fill_count", 32'(fill_count), mq.size());
    check_output("cmp_empty", 32'(empty), 32'(mq.size() == 0));
    check_output("cmp_full", 32'(full), 32'(mq.size() == DEPTH));
    check_output("cmp_overflow", 32'(overflow), 32'(m_ovf));
  end

  task automatic apply_stimulus(input logic we, input logic [DW-1:0] d, input logic clr);
    @(negedge clk);
    wr_en   = we;
    wr_data = d;
    ovf_clr = clr;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_pulses(input int target, input int limit, input string name);
    int n;
    n = 0;
    while (p_data.size() < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_output(name, p_data.size(), target);
  endtask

  // Hard stop in case something wedges outside the bounded waits
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios
  initial begin
    int k;
    int base;

    // 1: reset held with writes attempted
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 8'hEE, 1'b0);
      check_output("t1_tx_valid", 32'(tx_valid), 32'd0);
      check_output("t1_tx_data", 32'(tx_data), 32'd0);
      check_output("t1_empty", 32'(empty), 32'd1);
      check_output("t1_full", 32'(full), 32'd0);
      check_output("t1_fill", 32'(fill_count), 32'd0);
      check_output("t1_overflow", 32'(overflow), 32'd0);
    end
    apply_stimulus(1'b0, 8'h00, 1'b0);
    #1 rst = 1'b1;
    idle_cycles(3);

    // 2: single byte latency
    base = p_data.size();
    apply_stimulus(1'b1, 8'hA5, 1'b0);
    k = tb_cyc;
    apply_stimulus(1'b0, 8'h00, 1'b0);
    wait_pulses(base + 1, 20, "t2_pulse_seen");
    idle_cycles(4);
    if (p_data.size() > base) begin
      check_output("t2_latency", p_cyc[base] - k, 2);
      check_output("t2_data", 32'(p_data[base]), 32'hA5);
    end
    check_output("t2_single_pulse", p_data.size(), base + 1);
    check_output("t2_fill_after", 32'(fill_count), 32'd0);

    // 3: three bytes paced by the transmitter model
    auto_busy = 1'b1;
    base = p_data.size();
    apply_stimulus(1'b1, 8'h11, 1'b0);
    apply_stimulus(1'b1, 8'h22, 1'b0);
    apply_stimulus(1'b1, 8'h33, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0);
    wait_pulses(base + 3, 100, "t3_pulses_seen");
    idle_cycles(20);
    check_output("t3_pulse_count", p_data.size(), base + 3);
    if (p_data.size() >= base + 3) begin
      check_output("t3_byte0", 32'(p_data[base]), 32'h11);
      check_output("t3_byte1", 32'(p_data[base + 1]), 32'h22);
      check_output("t3_byte2", 32'(p_data[base + 2]), 32'h33);
      check_output("t3_gap01", p_cyc[base + 1] - p_cyc[base], 14);
      check_output("t3_gap12", p_cyc[base + 2] - p_cyc[base + 1], 14);
    end
    auto_busy = 1'b0;
    man_busy  = 1'b0;
    idle_cycles(2);

    // 4: fill while busy, overflow, clear, drain
    man_busy = 1'b1;
    base = p_data.size();
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(1'b1, 8'h40 + 8'(i), 1'b0);
      if (i == 8) begin
        check_output("t4_full_after8", 32'(full), 32'd1);
        check_output("t4_fill_after8", 32'(fill_count), 32'd8);
      end
    end
    apply_stimulus(1'b0, 8'h00, 1'b0);
    check_output("t4_fill_after9", 32'(fill_count), 32'd8);
    check_output("t4_overflow_set", 32'(overflow), 32'd1);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    apply_stimulus(1'b0, 8'h00, 1'b0);
    check_output("t4_overflow_clr", 32'(overflow), 32'd0);
    check_output("t4_no_issue_busy", p_data.size(), base);
    man_busy = 1'b0;
    wait_pulses(base + 8, 100, "t4_pulses_seen");
    idle_cycles(10);
    check_output("t4_pulse_count", p_data.size(), base + 8);
    if (p_data.size() >= base + 8) begin
      for (int i = 0; i < 8; i++) begin
        check_output("t4_order", 32'(p_data[base + i]), 32'h40 + i);
      end
      check_output("t4_idle_spacing", p_cyc[base + 1] - p_cyc[base], 4);
    end

    // 5: reset while waiting on the transmitter
    apply_stimulus(1'b1, 8'h51, 1'b0);
    apply_stimulus(1'b1, 8'h52, 1'b0);
    apply_stimulus(1'b1, 8'h53, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0);
    man_busy = 1'b1;
    idle_cycles(3);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check_output("t5_empty", 32'(empty), 32'd1);
    check_output("t5_tx_valid", 32'(tx_valid), 32'd0);
    check_output("t5_fill", 32'(fill_count), 32'd0);
    idle_cycles(2);
    man_busy = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    base = p_data.size();
    idle_cycles(12);
    check_output("t5_no_pulse", p_data.size(), base);

    // 6: stream of 20 bytes with random producer gaps
    base = p_data.size();
    for (int i = 0; i < 20; i++) begin
      int gap;
      int guard;
      gap = $urandom_range(0, 2);
      idle_cycles(gap + 1);
      guard = 0;
      while (full && guard < 50) begin
        apply_stimulus(1'b0, 8'h00, 1'b0);
        guard++;
      end
      apply_stimulus(1'b1, 8'(i), 1'b0);
    end
    apply_stimulus(1'b0, 8'h00, 1'b0);
    wait_pulses(base + 20, 300, "t6_pulses_seen");
    idle_cycles(6);
    check_output("t6_pulse_count", p_data.size(), base + 20);
    if (p_data.size() >= base + 20) begin
      for (int i = 0; i < 20; i++) begin
        check_output("t6_order", 32'(p_data[base + i]), i);
      end
    end
    check_output("t6_overflow", 32'(overflow), 32'd0);
    check_output("t6_empty", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
